// File: rtl/ppu_bg_pipeline.sv
// ppu_bg_pipeline -- background fetch-and-shift pipeline for one PPU scanline.
//
// For each tile the fetcher reads the nametable, attribute and two pattern
// bytes from VRAM. It packs the decoded tile into a small FIFO. A one-tile
// shifter drains the FIFO and emits one 5-bit palette address per accepted
// pixel_en.
//
// Parameters:
//   TILES_PER_LINE  visible tiles per line (1..32)
//   MEM_LAT         cycles from address issue to VRAM_data_in valid (1..4)
//   FIFO_DEPTH      decoded-tile FIFO entries (power of two, 2..8)
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   start             begin a line (ignored while busy); samples y_idx,
//                     scroll_x, bg_pt_addr, bg_show_left
//   VRAM_addr/_rd     read request (rd high for the issue cycle only)
//   VRAM_data_in      read data, MEM_LAT cycles after issue
//   pixel_en          consumer takes the current pixel
//   pixel/pixel_valid registered pixel {0, AT_hi, AT_lo, PT_hi, PT_lo}
//   line_done         one-cycle pulse after the last pixel is consumed
//   busy              accepted start .. line_done
//
// Build option: define PPU_BG_CLIP_EN so that bg_show_left=0 blanks the
// first 8 pixels of each line.
module ppu_bg_pipeline #(
  parameter int TILES_PER_LINE = 32,
  parameter int MEM_LAT        = 1,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  y_idx,
  input  logic [8:0]  scroll_x,
  input  logic        bg_pt_addr,
  input  logic        bg_show_left,
  output logic [15:0] VRAM_addr,
  output logic        VRAM_rd,
  input  logic [7:0]  VRAM_data_in,
  input  logic        pixel_en,
  output logic [4:0]  pixel,
  output logic        pixel_valid,
  output logic        line_done,
  output logic        busy
);

  localparam int PIX_TOTAL = TILES_PER_LINE * 8;
  localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef PPU_BG_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] at;
    logic [7:0] lo;
    logic [7:0] hi;
  } tile_t;

  typedef enum logic [2:0] {S_IDLE, S_NT, S_AT, S_PT_LO, S_PT_HI, S_DONE} state_t;

  // line context sampled at start
  logic [7:0] y_r;
  logic [8:0] sx_r;
  logic       pt_sel_r;
  logic       clip_r;

  // fetcher
  state_t     state;
  logic [2:0] cnt;       // cycles since address issue
  logic       issued;    // NT only: read for this tile has gone out
  logic [5:0] t;         // tile index within the line
  logic [7:0] nt_byte, lo_byte;
  logic [1:0] at_bits;
  logic [5:0] ntiles;
  logic       data_ok;

  // fifo
  tile_t         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          push, pop, flush;

  // shifter
  tile_t      sh;
  logic [2:0] idx;
  logic       first;     // next load is the first tile of the line
  logic [8:0] pix_cnt;   // pixels consumed so far this line
  logic       consume, last_pix, accept;

  tile_t      nxt_sh;
  logic [2:0] nxt_idx;
  logic       nxt_valid, nxt_first;
  logic [8:0] nxt_cnt;

  // ---------------------------------------------------------------- address
  function automatic logic [5:0] tsum(input logic [5:0] ti, input logic [8:0] sx);
    return {1'b0, sx[7:3]} + ti;
  endfunction

  function automatic logic [15:0] nt_addr(input logic [5:0] ti, input logic [8:0] sx,
                                          input logic [7:0] y);
    logic [5:0] s;
    s = tsum(ti, sx);
    return 16'h2000 | {5'b0, sx[8] ^ s[5], 10'b0} | {6'b0, y[7:3], 5'b0} | {11'b0, s[4:0]};
  endfunction

  function automatic logic [15:0] at_addr(input logic [5:0] ti, input logic [8:0] sx,
                                          input logic [7:0] y);
    logic [5:0] s;
    s = tsum(ti, sx);
    return 16'h23C0 | {5'b0, sx[8] ^ s[5], 10'b0} | {10'b0, y[7:5], 3'b0} | {13'b0, s[4:2]};
  endfunction

  function automatic logic [15:0] pt_addr(input logic half);
    return {3'b0, pt_sel_r, nt_byte, half, y_r[2:0]};
  endfunction

  // quadrant {y[4], cx[1]} picks one 2-bit field of the attribute byte
  function automatic logic [1:0] at_sel(input logic [7:0] d, input logic [5:0] ti);
    logic [5:0] s;
    s = tsum(ti, sx_r);
    case ({y_r[4], s[1]})
      2'b11:   return d[7:6];
      2'b10:   return d[5:4];
      2'b01:   return d[3:2];
      default: return d[1:0];
    endcase
  endfunction

  function automatic logic [4:0] pix_of(input tile_t tl, input logic [2:0] b,
                                        input logic [8:0] n);
    logic [4:0] p;
    p = {1'b0, tl.at, tl.hi[b], tl.lo[b]};
    if (CLIP_EN && clip_r && n < 9'd8) p = 5'd0;
    return p;
  endfunction

  // ---------------------------------------------------------------- control
  assign ntiles   = 6'(TILES_PER_LINE) + {5'd0, |sx_r[2:0]};
  assign data_ok  = issued && (cnt == 3'(MEM_LAT));
  assign push     = (state == S_PT_HI) && data_ok;
  assign accept   = start && !busy;
  assign consume  = pixel_en && pixel_valid;
  assign last_pix = consume && (pix_cnt == 9'(PIX_TOTAL - 1));
  assign flush    = last_pix;

  // ---------------------------------------------------------------- fetcher
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      issued    <= 1'b0;
      t         <= '0;
      nt_byte   <= '0;
      lo_byte   <= '0;
      at_bits   <= '0;
      y_r       <= '0;
      sx_r      <= '0;
      pt_sel_r  <= 1'b0;
      clip_r    <= 1'b0;
      VRAM_addr <= '0;
      VRAM_rd   <= 1'b0;
    end else begin
      VRAM_rd <= 1'b0;
      if (state != S_IDLE && issued && !data_ok) cnt <= cnt + 3'd1;
      case (state)
        S_IDLE: if (accept) begin
          y_r       <= y_idx;
          sx_r      <= scroll_x;
          pt_sel_r  <= bg_pt_addr;
          clip_r    <= ~bg_show_left;
          t         <= '0;
          VRAM_addr <= nt_addr(6'd0, scroll_x, y_idx);
          VRAM_rd   <= 1'b1;
          issued    <= 1'b1;
          cnt       <= '0;
          state     <= S_NT;
        end
        S_NT: begin
          if (!issued) begin
            // stalled on a full FIFO; go as soon as a slot frees up
            if ((fifo_cnt - (AW+1)'(pop)) < (AW+1)'(FIFO_DEPTH)) begin
              VRAM_addr <= nt_addr(t, sx_r, y_r);
              VRAM_rd   <= 1'b1;
              issued    <= 1'b1;
              cnt       <= '0;
            end
          end else if (data_ok) begin
            nt_byte   <= VRAM_data_in;
            VRAM_addr <= at_addr(t, sx_r, y_r);
            VRAM_rd   <= 1'b1;
            cnt       <= '0;
            state     <= S_AT;
          end
        end
        S_AT: if (data_ok) begin
          at_bits   <= at_sel(VRAM_data_in, t);
          VRAM_addr <= pt_addr(1'b0);
          VRAM_rd   <= 1'b1;
          cnt       <= '0;
          state     <= S_PT_LO;
        end
        S_PT_LO: if (data_ok) begin
          lo_byte   <= VRAM_data_in;
          VRAM_addr <= pt_addr(1'b1);
          VRAM_rd   <= 1'b1;
          cnt       <= '0;
          state     <= S_PT_HI;
        end
        S_PT_HI: if (data_ok) begin
          if (t == ntiles - 6'd1) begin
            state <= S_DONE;
          end else begin
            t     <= t + 6'd1;
            state <= S_NT;
            cnt   <= '0;
            // room left after this cycle's push (and any pop)?
            if ((fifo_cnt - (AW+1)'(pop)) < (AW+1)'(FIFO_DEPTH - 1)) begin
              VRAM_addr <= nt_addr(t + 6'd1, sx_r, y_r);
              VRAM_rd   <= 1'b1;
              issued    <= 1'b1;
            end else begin
              issued    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (last_pix) state <= S_IDLE;
    end
  end

  // ---------------------------------------------------------------- fifo
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{at: at_bits, lo: lo_byte, hi: VRAM_data_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // ---------------------------------------------------------------- shifter
  always_comb begin
    nxt_sh    = sh;
    nxt_idx   = idx;
    nxt_valid = pixel_valid;
    nxt_first = first;
    nxt_cnt   = pix_cnt;
    pop       = 1'b0;
    if (consume) begin
      nxt_cnt = pix_cnt + 9'd1;
      if (idx == 3'd0) nxt_valid = 1'b0;
      else             nxt_idx   = idx - 3'd1;
    end
    // refill when empty, or in the same cycle the last bit leaves (no bubble)
    if (busy && !last_pix && fifo_cnt != '0 &&
        (!pixel_valid || (consume && idx == 3'd0))) begin
      pop       = 1'b1;
      nxt_sh    = fifo_mem[rd_ptr];
      nxt_idx   = first ? 3'd7 - sx_r[2:0] : 3'd7;
      nxt_valid = 1'b1;
      nxt_first = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh          <= '0;
      idx         <= '0;
      first       <= 1'b0;
      pix_cnt     <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      line_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      line_done <= last_pix;
      if (last_pix) begin
        pixel_valid <= 1'b0;
        pixel       <= '0;
        pix_cnt     <= '0;
        busy        <= 1'b0;
        first       <= 1'b0;
      end else if (accept) begin
        busy    <= 1'b1;
        first   <= 1'b1;
        pix_cnt <= '0;
      end else begin
        sh          <= nxt_sh;
        idx         <= nxt_idx;
        first       <= nxt_first;
        pix_cnt     <= nxt_cnt;
        pixel_valid <= nxt_valid;
        pixel       <= nxt_valid ? pix_of(nxt_sh, nxt_idx, nxt_cnt) : 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_ppu_bg_pipeline.sv
// Scoreboard bench for ppu_bg_pipeline: expected VRAM addresses and pixels are
// computed from the bench's VRAM image at start and compared as the DUT
// issues reads and emits consumed pixels.
module tb_ppu_bg_pipeline;
  localparam int TPL = 32, LAT = 1, DEP = 2, TOTAL = TPL * 8;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [7:0]  y_idx = '0;
  logic [8:0]  scroll_x = '0;
  logic        bg_pt_addr = 1'b0, bg_show_left = 1'b1;
  logic [15:0] VRAM_addr;
  logic        VRAM_rd;
  logic [7:0]  VRAM_data_in;
  logic        pixel_en = 1'b0;
  logic [4:0]  pixel;
  logic        pixel_valid, line_done, busy;

  ppu_bg_pipeline #(.TILES_PER_LINE(TPL), .MEM_LAT(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .y_idx(y_idx), .scroll_x(scroll_x),
    .bg_pt_addr(bg_pt_addr), .bg_show_left(bg_show_left), .VRAM_addr(VRAM_addr),
    .VRAM_rd(VRAM_rd), .VRAM_data_in(VRAM_data_in), .pixel_en(pixel_en), .pixel(pixel),
    .pixel_valid(pixel_valid), .line_done(line_done), .busy(busy));

  always #5 clk = ~clk;

  // VRAM model: data for an address issued in cycle c is visible in c+LAT
  logic [7:0]  vram [65536];
  logic [15:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= VRAM_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign VRAM_data_in = vram[apipe[LAT-1]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  int n_rd, n_pix, n_done, start_cyc, en_mode = 0;
  bit done_flag, seen_valid, seen_rd;
  logic [15:0] exp_addr [$];
  logic [4:0]  exp_pix  [$];
  logic [15:0] rd_log   [$];
  logic [4:0]  pix_log  [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // pixel_en pattern: 0 tied high, 1 random, 2 held low
  initial forever begin
    @(posedge clk); #1;
    case (en_mode)
      0:       pixel_en = 1'b1;
      1:       pixel_en = 1'($urandom_range(0, 1));
      default: pixel_en = 1'b0;
    endcase
  end

  task automatic model_line(input logic [7:0] y, input logic [8:0] sx, input logic pt,
                            input logic show);
    int fine, ntl, k, s, cx, ntb, q;
    logic [15:0] a_nt, a_at, a_lo;
    logic [7:0]  ntbyte, plo, phi, atbyte;
    logic [1:0]  atb;
    logic [4:0]  pv;
    fine = int'(sx[2:0]);
    ntl  = TPL + ((fine != 0) ? 1 : 0);
    k    = 0;
    for (int ti = 0; ti < ntl; ti++) begin
      s    = int'(sx[7:3]) + ti;
      cx   = s % 32;
      ntb  = int'(sx[8]) ^ ((s >= 32) ? 1 : 0);
      a_nt = 16'(32'h2000 + ntb * 1024 + int'(y[7:3]) * 32 + cx);
      a_at = 16'(32'h23C0 + ntb * 1024 + int'(y[7:5]) * 8 + cx / 4);
      ntbyte = vram[a_nt];
      a_lo = 16'(int'(pt) * 4096 + int'(ntbyte) * 16 + int'(y[2:0]));
      atbyte = vram[a_at];
      q    = (y[4] ? 2 : 0) + ((cx / 2) % 2);
      atb  = 2'((atbyte >> (2 * q)) & 8'h3);
      plo  = vram[a_lo];
      phi  = vram[a_lo + 16'd8];
      exp_addr.push_back(a_nt);
      exp_addr.push_back(a_at);
      exp_addr.push_back(a_lo);
      exp_addr.push_back(a_lo + 16'd8);
      for (int b = 7; b >= 0; b--) begin
        if (!(ti == 0 && b > 7 - fine) && k < TOTAL) begin
          pv = {1'b0, atb, phi[b], plo[b]};
`ifdef PPU_BG_CLIP_EN
          if (!show && k < 8) pv = 5'd0;
`endif
          exp_pix.push_back(pv);
          k++;
        end
      end
    end
  endtask

  task automatic do_start(input logic [7:0] y, input logic [8:0] sx, input logic pt,
                          input logic show);
    @(posedge clk); #1;
    rd_log.delete(); pix_log.delete();
    n_rd = 0; n_pix = 0; n_done = 0;
    done_flag = 0; seen_valid = 0; seen_rd = 0;
    model_line(y, sx, pt, show);
    y_idx = y; scroll_x = sx; bg_pt_addr = pt; bg_show_left = show;
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_flag; i++) @(posedge clk);
    chk("line_timeout", 32'(done_flag), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", n_done, 1);
    chk("busy_after", busy, 0);
  endtask

  // scoreboard / monitor, sampled mid-cycle
  always @(negedge clk) if (reset_n) begin
    if (VRAM_rd) begin
      if (!seen_rd) begin
        seen_rd = 1;
        chk("first_rd_lat", cyc - start_cyc, 1);
      end
      n_rd++;
      rd_log.push_back(VRAM_addr);
      if (exp_addr.size() == 0) chk("rd_extra", VRAM_addr, 32'hFFFF_FFFF);
      else                      chk("rd_addr", VRAM_addr, exp_addr.pop_front());
    end
    if (pixel_valid && !seen_valid) begin
      seen_valid = 1;
      chk("first_pix_lat", cyc - start_cyc, 2 + 4 * (LAT + 1));
    end
    if (pixel_valid && pixel_en) begin
      n_pix++;
      pix_log.push_back(pixel);
      if (exp_pix.size() == 0) chk("pix_extra", pixel, 32'hFFFF_FFFF);
      else                     chk("pix", pixel, exp_pix.pop_front());
    end
    if (line_done) begin
      n_done++;
      done_flag = 1;
      chk("done_npix", n_pix, TOTAL);
      chk("done_busy", busy, 0);
      chk("done_q", exp_pix.size() + exp_addr.size(), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [4:0] p0;
    for (int i = 0; i < 65536; i++) vram[i] = 8'($urandom);

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", VRAM_addr, 0);
    chk("rst_rd", VRAM_rd, 0);
    chk("rst_pix", pixel, 0);
    chk("rst_valid", pixel_valid, 0);
    chk("rst_done", line_done, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;

    // basic line with known tile 0
    vram[16'h2000] = 8'h05; vram[16'h23C0] = 8'hE4;
    vram[16'h0050] = 8'hF0; vram[16'h0058] = 8'h0F;
    en_mode = 0;
    do_start(8'd0, 9'd0, 1'b0, 1'b1);
    wait_done(3000);
    chk("t1_a0", rd_log[0], 16'h2000);
    chk("t1_a1", rd_log[1], 16'h23C0);
    chk("t1_a2", rd_log[2], 16'h0050);
    chk("t1_a3", rd_log[3], 16'h0058);
    for (int i = 0; i < 8; i++) chk("t1_px", pix_log[i], (i < 4) ? 5'h01 : 5'h02);

    // coarse 31: wrap into the other nametable, AT quadrant [7:6]
    vram[16'h23C7] = 8'hC0;
    en_mode = 1;
    do_start(8'd16, 9'b0_11111_000, 1'b0, 1'b1);
    wait_done(4000);
    chk("t2_nt0", rd_log[0], 16'h205F);
    chk("t2_at0", rd_log[1], 16'h23C7);
    chk("t2_nt1", rd_log[4], 16'h2440);
    p0 = pix_log[0];
    chk("t2_at_q", p0[3:2], 2'b11);

    // fine scroll 3: 33 tiles fetched, still 256 pixels
    en_mode = 0;
    do_start(8'd37, 9'b0_00010_011, 1'b1, 1'b1);
    wait_done(3000);
    chk("t3_nrd", n_rd, 4 * (TPL + 1));

    // consumer stall: fetcher parks with the FIFO full
    en_mode = 2;
    do_start(8'd200, 9'b1_00111_110, 1'b0, 1'b1);
    repeat (200) @(posedge clk);
    #1;
    chk("stall_nrd", n_rd, 4 * (1 + DEP));
    chk("stall_rd_low", VRAM_rd, 0);
    chk("stall_valid", pixel_valid, 1);
    // start while busy must be ignored
    start = 1'b1; scroll_x = 9'h1FF; y_idx = 8'd99;
    @(posedge clk); #1;
    start = 1'b0;
    en_mode = 1;
    wait_done(4000);

    // reset mid-line, then a clean full line
    en_mode = 1;
    do_start(8'd77, 9'b0_01010_001, 1'b1, 1'b1);
    repeat (60) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_addr", VRAM_addr, 0);
    chk("mrst_rd", VRAM_rd, 0);
    chk("mrst_pix", pixel, 0);
    chk("mrst_valid", pixel_valid, 0);
    chk("mrst_done", line_done, 0);
    chk("mrst_busy", busy, 0);
    exp_addr.delete(); exp_pix.delete();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    do_start(8'd77, 9'b0_01010_001, 1'b1, 1'b1);
    wait_done(4000);

    // left clip request (blanked only when the build option is on)
    en_mode = 0;
    do_start(8'd8, 9'b1_00000_101, 1'b0, 1'b0);
    wait_done(3000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
